sdram_init_ctrl: RTL

//  SDRAM power-up initialisation sequencer, directly downstream of the PLL/reset controller.

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_init_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, init state enum and mode-register helpers
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    ST_WAIT, ST_PRE, ST_TRP, ST_AREF, ST_TRFC, ST_MRS, ST_TMRD, ST_DONE
  } init_state_t;

  localparam logic [2:0] BL_1    = 3'b000;
  localparam logic [2:0] BL_2    = 3'b001;
  localparam logic [2:0] BL_4    = 3'b010;
  localparam logic [2:0] BL_8    = 3'b011;
  localparam logic [2:0] BL_PAGE = 3'b111;

  // {reserved, write-burst mode, op mode, CAS latency, burst type, burst length}
  function automatic logic [12:0] mode_word(input logic [2:0] cas, input logic bt,
                                            input logic [2:0] bl);
    return {3'b000, 1'b0, 2'b00, cas, bt, bl};
  endfunction

endpackage

// File: rtl/sdram_init_ctrl.sv
// rtl/sdram_init_ctrl.sv - SDRAM power-up sequencer: wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int          INIT_WAIT_CYC = 20000,
  parameter int          TRP_CYC       = 2,
  parameter int          TRFC_CYC      = 7,
  parameter int          TMRD_CYC      = 2,
  parameter int          REFRESH_NUM   = 8,
  parameter logic [12:0] MODE_REG      = 13'h037
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        init_cke,
  output logic [3:0]  init_cmd,
  output logic [1:0]  init_ba,
  output logic [12:0] init_addr,
  output logic        init_done
);

  localparam int MAX_A = (INIT_WAIT_CYC > TRP_CYC)  ? INIT_WAIT_CYC : TRP_CYC;
  localparam int MAX_B = (TRFC_CYC > TMRD_CYC)      ? TRFC_CYC      : TMRD_CYC;
  localparam int MAX_T = (MAX_A > MAX_B)            ? MAX_A         : MAX_B;
  localparam int CW    = $clog2(MAX_T) + 1;
  localparam int RW    = $clog2(REFRESH_NUM + 1);

  localparam logic [CW-1:0] WAIT_C = CW'(INIT_WAIT_CYC);
  localparam logic [CW-1:0] TRP_C  = CW'(TRP_CYC);
  localparam logic [CW-1:0] TRFC_C = CW'(TRFC_CYC);
  localparam logic [CW-1:0] TMRD_C = CW'(TMRD_CYC);
  localparam logic [RW-1:0] REF_C  = RW'(REFRESH_NUM);

  init_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] ref_cnt, ref_nxt;
  logic [3:0]    cmd_nxt;
  logic [12:0]   addr_nxt;

  // cnt holds cycles elapsed since the last issued command (1 in the issue cycle),
  // so the next command fires once cnt reaches T; with T=1 the gap state is skipped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ref_nxt   = ref_cnt;
    unique case (state)
      ST_WAIT: begin
        if (cnt >= WAIT_C) begin
          state_nxt = ST_PRE;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_PRE, ST_TRP: begin
        if (cnt >= TRP_C) begin
          state_nxt = ST_AREF;
          cnt_nxt   = CW'(1);
          ref_nxt   = ref_cnt + RW'(1);
        end else begin
          state_nxt = ST_TRP;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      ST_AREF, ST_TRFC: begin
        if (cnt >= TRFC_C) begin
          cnt_nxt = CW'(1);
          if (ref_cnt < REF_C) begin
            state_nxt = ST_AREF;
            ref_nxt   = ref_cnt + RW'(1);
          end else begin
            state_nxt = ST_MRS;
          end
        end else begin
          state_nxt = ST_TRFC;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      ST_MRS, ST_TMRD: begin
        if (cnt >= TMRD_C) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_TMRD;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_DONE;
    endcase
  end

  // Outputs are decoded from the next state so the registered command lines up with the state.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    unique case (state_nxt)
      ST_PRE: begin
        cmd_nxt  = CMD_PRE;
        addr_nxt = 13'h0400;
      end
      ST_AREF: cmd_nxt = CMD_AREF;
      ST_MRS: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = MODE_REG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT;
      cnt       <= '0;
      ref_cnt   <= '0;
      init_cke  <= 1'b0;
      init_cmd  <= CMD_NOP;
      init_ba   <= 2'b00;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ref_cnt   <= ref_nxt;
      init_cke  <= 1'b1;
      init_cmd  <= cmd_nxt;
      init_ba   <= 2'b00;
      init_addr <= addr_nxt;
      init_done <= (state_nxt == ST_DONE);
    end
  end

endmodule
